sram_axi_bridge: RTL and testbench

//  Converts the core's two SRAM-like ports (inst, data) into one AXI3 master. Sits directly

---
 rtl/sram_axi_bridge_pkg.sv | 24 ++
 rtl/sram_axi_bridge.sv | 250 +++++++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared IDs, FSM state encodings and address helpers for the SRAM-to-AXI bridge.
package sram_axi_bridge_pkg;

  localparam logic [3:0] AXI_INST_ID = 4'd0;
  localparam logic [3:0] AXI_DATA_ID = 4'd1;

  typedef enum logic [2:0] {
    RD_IDLE = 3'b001,
    RD_AR   = 3'b010,
    RD_R    = 3'b100
  } rdState_e;

  typedef enum logic [2:0] {
    WR_IDLE = 3'b001,
    WR_AW   = 3'b010,
    WR_B    = 3'b100
  } wrState_e;

  // Two byte addresses hit the same 32-bit word when their upper 30 bits match.
  function automatic logic sameWord(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst/data SRAM-like ports onto a single AXI3 master with one
// outstanding read and one outstanding write, single-beat bursts only.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = AXI_INST_ID,
  parameter logic [3:0] DATA_ID = AXI_DATA_ID
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  axi_arid,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  rdState_e    rdState_q, rdState_d;
  logic [31:0] rdAddr_q, rdAddr_d;
  logic [1:0]  rdSize_q, rdSize_d;
  logic [3:0]  rdId_q, rdId_d;

  wrState_e    wrState_q, wrState_d;
  logic [31:0] wrAddr_q, wrAddr_d;
  logic [1:0]  wrSize_q, wrSize_d;
  logic [3:0]  wrStrb_q, wrStrb_d;
  logic [31:0] wrData_q, wrData_d;
  logic        awDone_q, awDone_d;
  logic        wDone_q, wDone_d;

  logic wrBusy, rdDataBusy, instHazard, dataHazard;
  logic dataRdAddrOk, dataWrAddrOk, dataRdDataOk, dataWrDataOk;
  logic unusedOk;

  // Response fields carry nothing the core needs for single-beat OKAY-only traffic.
  assign unusedOk = &{1'b0, rresp, rlast, bid, bresp};

  // Any outstanding write blocks data reads (port serialisation) and same-word reads (RAW).
  assign wrBusy     = (wrState_q != WR_IDLE);
  assign rdDataBusy = (rdState_q != RD_IDLE) && (rdId_q == DATA_ID);
  assign instHazard = wrBusy && sameWord(wrAddr_q, inst_sram_addr);
  assign dataHazard = wrBusy && sameWord(wrAddr_q, data_sram_addr);

  // Read FSM state and latched request registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdState_q <= RD_IDLE;
      rdAddr_q  <= 32'd0;
      rdSize_q  <= 2'd0;
      rdId_q    <= 4'd0;
    end else begin
      rdState_q <= rdState_d;
      rdAddr_q  <= rdAddr_d;
      rdSize_q  <= rdSize_d;
      rdId_q    <= rdId_d;
    end
  end

  // Read FSM next-state: arbitrate data over inst, issue AR, route the R beat by rid.
  always_comb begin
    rdState_d         = rdState_q;
    rdAddr_d          = rdAddr_q;
    rdSize_d          = rdSize_q;
    rdId_d            = rdId_q;
    arvalid           = 1'b0;
    rready            = 1'b0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    dataRdAddrOk      = 1'b0;
    dataRdDataOk      = 1'b0;
    case (rdState_q)
      RD_IDLE: begin
        if (data_sram_req && !data_sram_wr && !wrBusy && !dataHazard) begin
          dataRdAddrOk = 1'b1;
          rdAddr_d     = data_sram_addr;
          rdSize_d     = data_sram_size;
          rdId_d       = DATA_ID;
          rdState_d    = RD_AR;
        end else if (inst_sram_req && !instHazard &&
                     !(data_sram_req && !data_sram_wr && !wrBusy)) begin
          inst_sram_addr_ok = 1'b1;
          rdAddr_d          = inst_sram_addr;
          rdSize_d          = inst_sram_size;
          rdId_d            = INST_ID;
          rdState_d         = RD_AR;
        end
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) rdState_d = RD_R;
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid) begin
          if (rid == INST_ID) inst_sram_data_ok = 1'b1;
          else                dataRdDataOk      = 1'b1;
          rdState_d = RD_IDLE;
        end
      end
      default: rdState_d = RD_IDLE;
    endcase
  end

  // Write FSM state, latched write payload and per-channel handshake flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrState_q <= WR_IDLE;
      wrAddr_q  <= 32'd0;
      wrSize_q  <= 2'd0;
      wrStrb_q  <= 4'd0;
      wrData_q  <= 32'd0;
      awDone_q  <= 1'b0;
      wDone_q   <= 1'b0;
    end else begin
      wrState_q <= wrState_d;
      wrAddr_q  <= wrAddr_d;
      wrSize_q  <= wrSize_d;
      wrStrb_q  <= wrStrb_d;
      wrData_q  <= wrData_d;
      awDone_q  <= awDone_d;
      wDone_q   <= wDone_d;
    end
  end

  // Write FSM next-state: AW and W complete independently, then wait for B.
  always_comb begin
    wrState_d    = wrState_q;
    wrAddr_d     = wrAddr_q;
    wrSize_d     = wrSize_q;
    wrStrb_d     = wrStrb_q;
    wrData_d     = wrData_q;
    awDone_d     = awDone_q;
    wDone_d      = wDone_q;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    dataWrAddrOk = 1'b0;
    dataWrDataOk = 1'b0;
    case (wrState_q)
      WR_IDLE: begin
        if (data_sram_req && data_sram_wr && !rdDataBusy) begin
          dataWrAddrOk = 1'b1;
          wrAddr_d     = data_sram_addr;
          wrSize_d     = data_sram_size;
          wrStrb_d     = data_sram_wstrb;
          wrData_d     = data_sram_wdata;
          awDone_d     = 1'b0;
          wDone_d      = 1'b0;
          wrState_d    = WR_AW;
        end
      end
      WR_AW: begin
        awvalid  = !awDone_q;
        wvalid   = !wDone_q;
        awDone_d = awDone_q || awready;
        wDone_d  = wDone_q || wready;
        if ((awDone_q || awready) && (wDone_q || wready)) begin
          awDone_d  = 1'b0;
          wDone_d   = 1'b0;
          wrState_d = WR_B;
        end
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) begin
          dataWrDataOk = 1'b1;
          wrState_d    = WR_IDLE;
        end
      end
      default: wrState_d = WR_IDLE;
    endcase
  end

  assign data_sram_addr_ok = dataRdAddrOk | dataWrAddrOk;
  assign data_sram_data_ok = dataRdDataOk | dataWrDataOk;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;
  assign axi_arid          = rid;

  assign arid    = rdId_q;
  assign araddr  = rdAddr_q;
  assign arsize  = {1'b0, rdSize_q};
  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = DATA_ID;
  assign awaddr  = wrAddr_q;
  assign awsize  = {1'b0, wrSize_q};
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = DATA_ID;
  assign wdata   = wrData_q;
  assign wstrb   = wrStrb_q;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays the AXI slave by hand,
// inputs change on the falling edge and outputs are sampled 1ns later.
module tb_sram_axi_bridge;

  logic        clk, resetn;
  logic        inst_sram_req;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  axi_arid, arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int compareCount = 0;
  int mismatchCount = 0;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .axi_arid(axi_arid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Free-running 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge, where stimulus is changed.
  task automatic applyStimulus();
    @(negedge clk);
  endtask

  // One counted comparison; a mismatch is reported and counted, never fatal to the run.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Linear sequence of directed steps with hand-computed expectations.
  initial begin
    resetn = 1'b0;
    inst_sram_req = 1'b0; inst_sram_size = 2'd2; inst_sram_addr = 32'd0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
    data_sram_wstrb = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'd0; bvalid = 1'b0;

    // Reset state.
    applyStimulus(); #1;
    checkOutput("rst_arvalid", {31'd0, arvalid}, 32'd0);
    checkOutput("rst_awvalid", {31'd0, awvalid}, 32'd0);
    checkOutput("rst_wvalid", {31'd0, wvalid}, 32'd0);
    checkOutput("rst_rready_bready", {30'd0, rready, bready}, 32'd0);
    checkOutput("rst_addr_ok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
    checkOutput("rst_araddr", araddr, 32'd0);
    applyStimulus(); resetn = 1'b1;

    // 1: single instruction fetch.
    applyStimulus();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0000; inst_sram_size = 2'd2;
    #1 checkOutput("t1_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    checkOutput("t1_data_addr_ok", {31'd0, data_sram_addr_ok}, 32'd0);
    applyStimulus(); inst_sram_req = 1'b0; arready = 1'b1;
    #1 checkOutput("t1_arvalid", {31'd0, arvalid}, 32'd1);
    checkOutput("t1_araddr", araddr, 32'h1c00_0000);
    checkOutput("t1_arid", {28'd0, arid}, 32'd0);
    checkOutput("t1_arsize", {29'd0, arsize}, 32'd2);
    checkOutput("t1_ar_consts", {24'd0, arlen, 2'd0, arburst}, 32'h0000_0001);
    applyStimulus(); arready = 1'b0;
    #1 checkOutput("t1_rready", {31'd0, rready}, 32'd1);
    checkOutput("t1_no_early_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    applyStimulus(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0c0c;
    #1 checkOutput("t1_inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    checkOutput("t1_inst_rdata", inst_sram_rdata, 32'h0280_0c0c);
    checkOutput("t1_axi_arid", {28'd0, axi_arid}, 32'd0);
    checkOutput("t1_data_data_ok", {31'd0, data_sram_data_ok}, 32'd0);
    applyStimulus(); rvalid = 1'b0;
    #1 checkOutput("t1_idle_rready", {31'd0, rready}, 32'd0);

    // 2: simultaneous inst and data reads, data wins.
    applyStimulus();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0004;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0100;
    #1 checkOutput("t2_data_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    checkOutput("t2_inst_waits", {31'd0, inst_sram_addr_ok}, 32'd0);
    applyStimulus(); data_sram_req = 1'b0; arready = 1'b1;
    #1 checkOutput("t2_araddr", araddr, 32'h0000_0100);
    checkOutput("t2_arid", {28'd0, arid}, 32'd1);
    checkOutput("t2_inst_busy", {31'd0, inst_sram_addr_ok}, 32'd0);
    applyStimulus(); arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'hdead_beef;
    #1 checkOutput("t2_data_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
    checkOutput("t2_data_rdata", data_sram_rdata, 32'hdead_beef);
    checkOutput("t2_inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    checkOutput("t2_axi_arid", {28'd0, axi_arid}, 32'd1);
    applyStimulus(); rvalid = 1'b0;
    #1 checkOutput("t2_inst_retry_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    applyStimulus(); inst_sram_req = 1'b0; arready = 1'b1;
    #1 checkOutput("t2_inst_araddr", araddr, 32'h1c00_0004);
    checkOutput("t2_inst_arid", {28'd0, arid}, 32'd0);
    applyStimulus(); arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h1234_5678;
    #1 checkOutput("t2_inst_data_ok2", {31'd0, inst_sram_data_ok}, 32'd1);
    applyStimulus(); rvalid = 1'b0;

    // 3: write with W accepted three cycles before AW.
    applyStimulus();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h0000_0200;
    data_sram_size = 2'd1; data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h0000_abcd;
    #1 checkOutput("t3_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    applyStimulus(); data_sram_req = 1'b0; wready = 1'b1;
    #1 checkOutput("t3_aw_w_valid", {30'd0, awvalid, wvalid}, 32'd3);
    checkOutput("t3_awaddr", awaddr, 32'h0000_0200);
    checkOutput("t3_awsize", {29'd0, awsize}, 32'd1);
    checkOutput("t3_wstrb", {28'd0, wstrb}, 32'd3);
    checkOutput("t3_wdata", wdata, 32'h0000_abcd);
    checkOutput("t3_ids_wlast", {23'd0, awid, wid, wlast}, {23'd0, 4'd1, 4'd1, 1'b1});
    applyStimulus(); wready = 1'b0;
    #1 checkOutput("t3_w_dropped", {30'd0, awvalid, wvalid}, 32'd2);
    applyStimulus();
    #1 checkOutput("t3_aw_held", {30'd0, awvalid, wvalid}, 32'd2);
    applyStimulus(); awready = 1'b1;
    #1 checkOutput("t3_aw_last", {30'd0, awvalid, wvalid}, 32'd2);
    applyStimulus(); awready = 1'b0;
    #1 checkOutput("t3_wr_b", {29'd0, awvalid, wvalid, bready}, 32'd1);
    checkOutput("t3_no_data_ok", {31'd0, data_sram_data_ok}, 32'd0);
    applyStimulus(); bvalid = 1'b1;
    #1 checkOutput("t3_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
    applyStimulus(); bvalid = 1'b0;
    #1 checkOutput("t3_idle_bready", {31'd0, bready}, 32'd0);

    // 4: data read to the word of an outstanding write waits for B.
    applyStimulus();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h0000_0300;
    data_sram_size = 2'd2; data_sram_wstrb = 4'hf; data_sram_wdata = 32'h5555_aaaa;
    #1 checkOutput("t4_wr_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    applyStimulus();
    data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0302; data_sram_size = 2'd1;
    awready = 1'b1; wready = 1'b1;
    #1 checkOutput("t4_rd_blocked_aw", {31'd0, data_sram_addr_ok}, 32'd0);
    applyStimulus(); awready = 1'b0; wready = 1'b0;
    #1 checkOutput("t4_rd_blocked_b", {31'd0, data_sram_addr_ok}, 32'd0);
    applyStimulus(); bvalid = 1'b1;
    #1 checkOutput("t4_wr_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
    checkOutput("t4_rd_blocked_bv", {31'd0, data_sram_addr_ok}, 32'd0);
    applyStimulus(); bvalid = 1'b0;
    #1 checkOutput("t4_rd_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    applyStimulus(); data_sram_req = 1'b0; arready = 1'b1;
    #1 checkOutput("t4_araddr", araddr, 32'h0000_0302);
    checkOutput("t4_arsize", {29'd0, arsize}, 32'd1);
    checkOutput("t4_arid", {28'd0, arid}, 32'd1);
    applyStimulus(); arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000_aaaa;
    #1 checkOutput("t4_rd_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
    applyStimulus(); rvalid = 1'b0;

    // 5: inst read to another word proceeds under a write; same word is held off.
    applyStimulus();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h0000_0300;
    data_sram_size = 2'd2;
    #1 checkOutput("t5_wr_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    applyStimulus(); data_sram_req = 1'b0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_0400; inst_sram_size = 2'd2;
    #1 checkOutput("t5_inst_no_hazard", {31'd0, inst_sram_addr_ok}, 32'd1);
    applyStimulus(); inst_sram_req = 1'b0; arready = 1'b1;
    #1 checkOutput("t5_araddr", araddr, 32'h0000_0400);
    applyStimulus(); arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_0400;
    #1 checkOutput("t5_inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    applyStimulus(); rvalid = 1'b0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_0301; awready = 1'b1; wready = 1'b1;
    #1 checkOutput("t5_inst_hazard_aw", {31'd0, inst_sram_addr_ok}, 32'd0);
    applyStimulus(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    #1 checkOutput("t5_inst_hazard_b", {31'd0, inst_sram_addr_ok}, 32'd0);
    applyStimulus(); bvalid = 1'b0;
    #1 checkOutput("t5_inst_after_b", {31'd0, inst_sram_addr_ok}, 32'd1);
    applyStimulus(); inst_sram_req = 1'b0; arready = 1'b1;
    #1 checkOutput("t5_hazard_araddr", araddr, 32'h0000_0301);

    // 6: asynchronous reset while waiting in RD_R.
    applyStimulus(); arready = 1'b0;
    #1 checkOutput("t6_rready_before", {31'd0, rready}, 32'd1);
    #2 resetn = 1'b0;
    #1 checkOutput("t6_rready_reset", {31'd0, rready}, 32'd0);
    checkOutput("t6_arvalid_reset", {31'd0, arvalid}, 32'd0);
    checkOutput("t6_araddr_reset", araddr, 32'd0);
    applyStimulus(); resetn = 1'b1;
    #1 checkOutput("t6_idle_after", {30'd0, arvalid, rready}, 32'd0);
    applyStimulus(); inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_0500;
    #1 checkOutput("t6_accept_after", {31'd0, inst_sram_addr_ok}, 32'd1);
    applyStimulus(); inst_sram_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
